// File: rtl/weight_cache_pingpong_if.sv
// ---------------------------------------------------------------------------
// weight_cache_pingpong_if
//   Bundles every non-clock signal of the ping-pong weight cache.
//   master : the upstream controller / weight streamer (drives commands,
//            weight beats and read requests, observes the cache outputs)
//   slave  : the weight cache itself
//
//   start          1-cycle pulse, latch Matrix_Row/Matrix_Col, begin a load
//   Matrix_Row     rows of the weight matrix (K*K*Cin)
//   Matrix_Col     output channels
//   sData_valid    weight stream valid
//   sData_ready    weight stream ready
//   sData_payload  LANES weights, lane 0 in the low DATA_W bits
//   Raddr_Valid    read request, advance read pointer one word
//   LayerEnd       1-cycle pulse, release the current read bank
//   mData          weight word to the array
//   mValid         mData valid (one cycle after an accepted read)
//   Weight_Cached  read bank holds a complete layer
//   bank_sel       index of the current read bank
//   cfg_err        sticky illegal-size flag
// ---------------------------------------------------------------------------
interface weight_cache_pingpong_if #(
    parameter int DATA_W = 8,
    parameter int LANES  = 8
);
    localparam int W = DATA_W * LANES;

    logic          start;
    logic [15:0]   Matrix_Row;
    logic [15:0]   Matrix_Col;
    logic          sData_valid;
    logic          sData_ready;
    logic [W-1:0]  sData_payload;
    logic          Raddr_Valid;
    logic          LayerEnd;
    logic [W-1:0]  mData;
    logic          mValid;
    logic          Weight_Cached;
    logic          bank_sel;
    logic          cfg_err;

    modport master (
        output start, Matrix_Row, Matrix_Col, sData_valid, sData_payload,
               Raddr_Valid, LayerEnd,
        input  sData_ready, mData, mValid, Weight_Cached, bank_sel, cfg_err
    );

    modport slave (
        input  start, Matrix_Row, Matrix_Col, sData_valid, sData_payload,
               Raddr_Valid, LayerEnd,
        output sData_ready, mData, mValid, Weight_Cached, bank_sel, cfg_err
    );
endinterface

// File: rtl/weight_cache_pingpong.sv
// ---------------------------------------------------------------------------
// weight_cache_pingpong
//   Double-buffered weight cache for the systolic array. One bank is filled
//   from the valid/ready weight stream while the other is replayed word by
//   word under Raddr_Valid, so the next layer's weights load during the
//   current layer's compute.
//
//   Ports
//     clk    : clock, all logic on the rising edge
//     reset  : asynchronous, active-low reset
//     bus    : weight_cache_pingpong_if.slave (command, stream, read side)
//
//   Parameters
//     DATA_W : bits per weight element
//     LANES  : weights per word (array columns), word width = LANES*DATA_W
//     DEPTH  : words per bank
//     ADDR_W : clog2(DEPTH)
//
//   Words are stored tile-major, row-minor (addr = tile*Matrix_Row + row),
//   tiles = ceil(Matrix_Col/LANES); the sender zero-pads a partial tile.
// ---------------------------------------------------------------------------
module weight_cache_pingpong #(
    parameter int DATA_W = 8,
    parameter int LANES  = 8,
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    weight_cache_pingpong_if.slave      bus
);
    localparam int W     = DATA_W * LANES;
    localparam int CNT_W = ADDR_W + 1;   // word counts reach DEPTH itself

    typedef enum logic [1:0] {B_EMPTY, B_LOADING, B_FULL} bank_st_t;
    typedef enum logic [1:0] {S_IDLE, S_WAIT_BANK, S_LOAD} wr_st_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    wr_st_t             r_wr_state;
    wr_st_t             w_wr_state_next;
    bank_st_t           r_bank_st    [2];
    logic [CNT_W-1:0]   r_bank_total [2];
    logic               r_sel;
    logic               r_cached;
    logic [CNT_W-1:0]   r_wr_total;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic               r_wr_bank;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic               r_mvalid;
    logic               r_last_bank;
    logic               r_rd_seen;
    logic               r_cfg_err;

    // ------------------------------------------------------------------
    // Layer sizing
    // ------------------------------------------------------------------
    logic [16:0]        w_tiles;
    logic [31:0]        w_total;
    logic               w_size_bad;

    always_comb begin
        w_tiles    = ({1'b0, bus.Matrix_Col} + 17'(LANES - 1)) / 17'(LANES);
        w_total    = 32'(bus.Matrix_Row) * 32'(w_tiles);
        w_size_bad = (w_total == 32'd0) || (w_total > 32'(DEPTH));
    end

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic               w_beat;
    logic               w_last_beat;
    logic               w_le;
    logic               w_rd_acc;
    logic               w_sel_next;

    always_comb begin
        w_beat      = bus.sData_valid && (r_wr_state == S_LOAD);
        w_last_beat = w_beat && ({1'b0, r_wr_addr} == (r_wr_total - CNT_W'(1)));
        w_le        = bus.LayerEnd && r_cached;
        w_rd_acc    = bus.Raddr_Valid && r_cached;
        w_sel_next  = r_sel ^ w_le;
    end

    // Bank states after the read side has acted this cycle; the write
    // side then overrides (a bank freed by LayerEnd can be claimed for
    // loading in the same edge).
    bank_st_t           w_rd_st        [2];
    bank_st_t           w_bank_st_next [2];

    // ------------------------------------------------------------------
    // Write FSM: next-state / outputs
    // ------------------------------------------------------------------
    logic               w_tgt_now;
    logic               w_tgt_wait;
    logic               w_enter_load;
    logic               w_load_bank;
    logic [CNT_W-1:0]   w_load_total;
    logic               w_start_ok;
    logic               w_cfg_set;

    always_comb begin
        w_wr_state_next = r_wr_state;
        w_enter_load    = 1'b0;
        w_load_bank     = r_wr_bank;
        w_load_total    = r_wr_total;
        w_start_ok      = 1'b0;
        w_cfg_set       = 1'b0;
        // First layer loads straight into the (empty) read bank; otherwise
        // the free bank is the one not being read.
        w_tgt_now       = (r_bank_st[r_sel] == B_EMPTY) ? r_sel : ~r_sel;
        // While waiting, look at the post-LayerEnd picture so the bank that
        // is released this cycle is taken on the very next edge.
        w_tgt_wait      = (w_rd_st[w_sel_next] == B_EMPTY) ? w_sel_next : ~w_sel_next;

        case (r_wr_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_size_bad) begin
                        w_cfg_set = 1'b1;
                    end else begin
                        w_start_ok   = 1'b1;
                        w_load_total = w_total[CNT_W-1:0];
                        if (r_bank_st[w_tgt_now] == B_EMPTY) begin
                            w_enter_load    = 1'b1;
                            w_load_bank     = w_tgt_now;
                            w_wr_state_next = S_LOAD;
                        end else begin
                            w_wr_state_next = S_WAIT_BANK;
                        end
                    end
                end
            end
            S_WAIT_BANK: begin
                if (w_rd_st[w_tgt_wait] == B_EMPTY) begin
                    w_enter_load    = 1'b1;
                    w_load_bank     = w_tgt_wait;
                    w_wr_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_last_beat) begin
                    w_wr_state_next = S_IDLE;
                end
            end
            default: begin
                w_wr_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_state <= S_IDLE;
        end else begin
            r_wr_state <= w_wr_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Per-bank state next values
    // ------------------------------------------------------------------
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_rd_st[b] = (w_le && (r_sel == 1'(b))) ? B_EMPTY : r_bank_st[b];
            w_bank_st_next[b] = w_rd_st[b];
            if (w_last_beat && (r_wr_bank == 1'(b))) begin
                w_bank_st_next[b] = B_FULL;
            end
            if (w_enter_load && (w_load_bank == 1'(b))) begin
                w_bank_st_next[b] = B_LOADING;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bookkeeping registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                r_bank_st[b]    <= B_EMPTY;
                r_bank_total[b] <= '0;
            end
            r_sel       <= 1'b0;
            r_cached    <= 1'b0;
            r_wr_total  <= '0;
            r_wr_addr   <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_addr   <= '0;
            r_mvalid    <= 1'b0;
            r_last_bank <= 1'b0;
            r_rd_seen   <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                r_bank_st[b] <= w_bank_st_next[b];
                if (w_enter_load && (w_load_bank == 1'(b))) begin
                    r_bank_total[b] <= w_load_total;
                end
            end

            if (w_start_ok) begin
                r_wr_total <= w_total[CNT_W-1:0];
            end
            if (w_enter_load) begin
                r_wr_bank <= w_load_bank;
            end
            if (w_start_ok) begin
                r_wr_addr <= '0;
            end else if (w_beat) begin
                r_wr_addr <= r_wr_addr + ADDR_W'(1);
            end
            if (w_cfg_set) begin
                r_cfg_err <= 1'b1;
            end

            r_sel    <= w_sel_next;
            // Reflects the bank selected after this edge, so a load that
            // completes together with LayerEnd shows up as cached at once.
            r_cached <= (w_bank_st_next[w_sel_next] == B_FULL);

            r_mvalid <= w_rd_acc;
            if (w_rd_acc) begin
                r_last_bank <= r_sel;
                r_rd_seen   <= 1'b1;
            end

            // A read in the LayerEnd cycle is served from the old bank at
            // the old address; the pointer then restarts for the new bank.
            if (w_le) begin
                r_rd_addr <= '0;
            end else if (w_rd_acc) begin
                if ({1'b0, r_rd_addr} == (r_bank_total[r_sel] - CNT_W'(1))) begin
                    r_rd_addr <= '0;
                end else begin
                    r_rd_addr <= r_rd_addr + ADDR_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bank storage: one simple dual-port RAM per bank, registered read
    // ------------------------------------------------------------------
    logic [1:0][W-1:0]  w_ram_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [W-1:0] r_mem [DEPTH];
        logic [W-1:0] r_q;

        always_ff @(posedge clk) begin
            if (w_beat && (r_wr_bank == 1'(gi))) begin
                r_mem[r_wr_addr] <= bus.sData_payload;
            end
            if (w_rd_acc && (r_sel == 1'(gi))) begin
                r_q <= r_mem[r_rd_addr];
            end
        end

        assign w_ram_q[gi] = r_q;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // RAM output registers carry no reset; r_rd_seen forces mData to zero
    // until the first read after reset. The read register of the bank last
    // read only changes on a new read, so mData holds between requests.
    assign bus.mData         = r_rd_seen ? w_ram_q[r_last_bank] : '0;
    assign bus.mValid        = r_mvalid;
    assign bus.sData_ready   = (r_wr_state == S_LOAD);
    assign bus.Weight_Cached = r_cached;
    assign bus.bank_sel      = r_sel;
    assign bus.cfg_err       = r_cfg_err;

endmodule
